// File: rtl/pcs_6466b_pkg.sv
// Shared 64b/66b PCS definitions: block types, XGMII characters,
// fixed output blocks and the receive state/class enums.
package pcs_6466b_pkg;

   // Sync headers
   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;

   // Block type field values
   localparam logic [7:0] TYPE_CTL = 8'h1E;
   localparam logic [7:0] TYPE_OS  = 8'h4B;
   localparam logic [7:0] TYPE_S0  = 8'h78;
   localparam logic [7:0] TYPE_S4  = 8'h33;
   localparam logic [7:0] TYPE_T0  = 8'h87;
   localparam logic [7:0] TYPE_T1  = 8'h99;
   localparam logic [7:0] TYPE_T2  = 8'hAA;
   localparam logic [7:0] TYPE_T3  = 8'hB4;
   localparam logic [7:0] TYPE_T4  = 8'hCC;
   localparam logic [7:0] TYPE_T5  = 8'hD2;
   localparam logic [7:0] TYPE_T6  = 8'hE1;
   localparam logic [7:0] TYPE_T7  = 8'hFF;

   // XGMII characters
   localparam logic [7:0] IDLE  = 8'h07;
   localparam logic [7:0] START = 8'hFB;
   localparam logic [7:0] TERM  = 8'hFD;
   localparam logic [7:0] ERROR = 8'hFE;
   localparam logic [7:0] SEQ   = 8'h9C;

   // Fixed output blocks
   localparam logic [63:0] LF_BLOCK  = 64'h0100_009C_0100_009C;
   localparam logic [7:0]  LF_CTL    = 8'h11;
   localparam logic [63:0] ERR_BLOCK = 64'hFEFE_FEFE_FEFE_FEFE;
   localparam logic [7:0]  ERR_CTL   = 8'hFF;

   typedef enum logic [2:0] {
      RX_INIT,
      RX_C,
      RX_D,
      RX_T,
      RX_E
   } rx_state_t;

   typedef enum logic [2:0] {
      C,
      S,
      T,
      D,
      E
   } blk_class_t;

   // 7-bit line control code to XGMII char: only idle is recognised
   function automatic logic [7:0] ctl_char(input logic [6:0] c);
      return (c == 7'h00) ? IDLE : ERROR;
   endfunction

   // Terminate type to {is_term, data byte count}
   function automatic logic [3:0] term_k(input logic [7:0] t);
      logic [3:0] r;
      r = 4'b0000;
      case (t)
         TYPE_T0: r = {1'b1, 3'd0};
         TYPE_T1: r = {1'b1, 3'd1};
         TYPE_T2: r = {1'b1, 3'd2};
         TYPE_T3: r = {1'b1, 3'd3};
         TYPE_T4: r = {1'b1, 3'd4};
         TYPE_T5: r = {1'b1, 3'd5};
         TYPE_T6: r = {1'b1, 3'd6};
         TYPE_T7: r = {1'b1, 3'd7};
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decode_6466b_classify.sv
// Combinational block classifier and per-type lane decoder for
// the 64b/66b receive path.
module decode_6466b_classify
   import pcs_6466b_pkg::*;
(
   input  logic [1:0]  i_rx_header,
   input  logic [63:0] i_rxd,
   output blk_class_t  o_class,
   output logic [63:0] o_rxd,
   output logic [7:0]  o_rxctl
);

   logic [7:0]  w_type;
   logic [63:0] w_shift;
   logic [3:0]  w_term;
   logic [6:0]  w_cc [8];

   assign w_type  = i_rxd[7:0];
   assign w_shift = i_rxd >> 8;
   assign w_term  = term_k(w_type);

   // Slice out the eight 7-bit control codes following the type byte
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         w_cc[n] = i_rxd[8 + 7*n +: 7];
      end
   end

   // Classify the block and build its XGMII lanes
   always_comb begin
      o_class = E;
      o_rxd   = ERR_BLOCK;
      o_rxctl = ERR_CTL;
      if (i_rx_header == HDR_DATA) begin
         o_class = D;
         o_rxd   = i_rxd;
         o_rxctl = 8'h00;
      end else if (i_rx_header == HDR_CTRL) begin
         if (w_term[3]) begin
            o_class = T;
            o_rxctl = 8'hFF << w_term[2:0];
            for (int i = 0; i < 8; i++) begin
               if (i < int'(w_term[2:0]))
                  o_rxd[8*i +: 8] = w_shift[8*i +: 8];
               else if (i == int'(w_term[2:0]))
                  o_rxd[8*i +: 8] = TERM;
               else
                  o_rxd[8*i +: 8] = IDLE;
            end
         end else begin
            case (w_type)
               TYPE_CTL: begin
                  o_class = C;
                  o_rxctl = 8'hFF;
                  for (int n = 0; n < 8; n++) begin
                     o_rxd[8*n +: 8] = ctl_char(w_cc[n]);
                  end
               end
               TYPE_OS: begin
                  if (i_rxd[35:32] == 4'h0) begin
                     o_class = C;
                     o_rxd   = {{4{IDLE}}, i_rxd[31:8], SEQ};
                     o_rxctl = 8'hF1;
                  end
               end
               TYPE_S0: begin
                  o_class = S;
                  o_rxd   = {i_rxd[63:8], START};
                  o_rxctl = 8'h01;
               end
               TYPE_S4: begin
                  o_class = S;
                  o_rxd   = {i_rxd[63:40], START,
                             ctl_char(w_cc[3]),
                             ctl_char(w_cc[2]),
                             ctl_char(w_cc[1]),
                             ctl_char(w_cc[0])};
                  o_rxctl = 8'h1F;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/decode_6466b.sv
// 64b/66b receive decoder: receive state machine, output registers
// and optional saturating error counter (DECODE_ERR_COUNT_EN).
module decode_6466b
   import pcs_6466b_pkg::*;
(
   input  logic        i_rxc,
   input  logic        i_reset,
   input  logic        i_block_lock,
   input  logic        i_rx_valid,
   input  logic [63:0] i_rxd,
   input  logic [1:0]  i_rx_header,
   output logic [63:0] o_rxd,
   output logic [7:0]  o_rxctl
`ifdef DECODE_ERR_COUNT_EN
   ,
   output logic [15:0] o_err_count
`endif
);

   rx_state_t   r_state;
   rx_state_t   w_state_nxt;
   blk_class_t  w_class;
   logic [63:0] w_dec_rxd;
   logic [7:0]  w_dec_rxctl;
   logic [63:0] w_rxd_nxt;
   logic [7:0]  w_rxctl_nxt;
   logic [63:0] r_rxd;
   logic [7:0]  r_rxctl;

   decode_6466b_classify u_classify (
      .i_rx_header (i_rx_header),
      .i_rxd       (i_rxd),
      .o_class     (w_class),
      .o_rxd       (w_dec_rxd),
      .o_rxctl     (w_dec_rxctl)
   );

   // State register
   always_ff @(posedge i_rxc) begin
      if (i_reset)
         r_state <= RX_INIT;
      else
         r_state <= w_state_nxt;
   end

   // Next state: lock loss wins, pause cycles hold
   always_comb begin
      w_state_nxt = r_state;
      if (!i_block_lock) begin
         w_state_nxt = RX_INIT;
      end else if (i_rx_valid) begin
         case (r_state)
            RX_INIT, RX_C, RX_T: begin
               case (w_class)
                  C:       w_state_nxt = RX_C;
                  S:       w_state_nxt = RX_D;
                  default: w_state_nxt = RX_E;
               endcase
            end
            RX_D: begin
               case (w_class)
                  D:       w_state_nxt = RX_D;
                  T:       w_state_nxt = RX_T;
                  default: w_state_nxt = RX_E;
               endcase
            end
            RX_E: begin
               case (w_class)
                  C:       w_state_nxt = RX_C;
                  S, D:    w_state_nxt = RX_D;
                  T:       w_state_nxt = RX_T;
                  default: w_state_nxt = RX_E;
               endcase
            end
            default: w_state_nxt = RX_INIT;
         endcase
      end
   end

   // Output select: LF on lock loss, error block on entry to RX_E
   always_comb begin
      w_rxd_nxt   = r_rxd;
      w_rxctl_nxt = r_rxctl;
      if (!i_block_lock) begin
         w_rxd_nxt   = LF_BLOCK;
         w_rxctl_nxt = LF_CTL;
      end else if (i_rx_valid) begin
         if (w_state_nxt == RX_E) begin
            w_rxd_nxt   = ERR_BLOCK;
            w_rxctl_nxt = ERR_CTL;
         end else begin
            w_rxd_nxt   = w_dec_rxd;
            w_rxctl_nxt = w_dec_rxctl;
         end
      end
   end

   // Output registers, reset to local fault
   always_ff @(posedge i_rxc) begin
      if (i_reset) begin
         r_rxd   <= LF_BLOCK;
         r_rxctl <= LF_CTL;
      end else begin
         r_rxd   <= w_rxd_nxt;
         r_rxctl <= w_rxctl_nxt;
      end
   end

   assign o_rxd   = r_rxd;
   assign o_rxctl = r_rxctl;

`ifdef DECODE_ERR_COUNT_EN
   logic        w_err;
   logic [15:0] r_err_count;

   assign w_err = i_block_lock & i_rx_valid & (w_state_nxt == RX_E);

   // Saturating count of emitted error blocks
   always_ff @(posedge i_rxc) begin
      if (i_reset)
         r_err_count <= 16'h0000;
      else if (w_err && r_err_count != 16'hFFFF)
         r_err_count <= r_err_count + 16'h0001;
   end

   assign o_err_count = r_err_count;
`endif

endmodule
